io_handshake: RTL and testbench

Responder for the control unit's I/O stall protocol. On an IN or OUT instruction it raises `enterFlag`, which makes the control unit halt the processor. It releases the stall for exactly one cycle after a debounced press-and-release of the board's Enter key. In that cycle it presents the latched switch value for IN and keeps the display register updated for OUT.

---
 rtl/io_handshake_pkg.sv | 17 +
 rtl/io_debounce.sv | 55 +++++
 rtl/io_handshake.sv | 117 +++++++++++
 tb/tb_io_handshake.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_handshake_pkg.sv
// io_handshake_pkg
//   Shared definitions for the I/O stall responder:
//   - IO_DATA_W  : default datapath width
//   - io_state_e : handshake FSM encoding (IDLE=0, WAIT_PRESS=1,
//                  WAIT_RELEASE=2, DONE=3)
package io_handshake_pkg;

  localparam int unsigned IO_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } io_state_e;

endpackage

// File: rtl/io_debounce.sv
// io_debounce
//   Synchronizes the raw active-low Enter key and debounces it.
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-high reset
//     raw_n in   raw key, active-low, asynchronous
//     db    out  debounced key, 1 = pressed
//   The debounced output toggles once the synchronized key has differed
//   from it for DEBOUNCE_CYCLES consecutive cycles.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic db
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          w_key;

  assign w_key = ~r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      if (w_key != r_db) begin
        // terminal count reached while still differing: accept the change
        if (r_cnt == CNT_MAX) begin
          r_db  <= ~r_db;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign db = r_db;

endmodule

// File: rtl/io_handshake.sv
// io_handshake
//   Responder for the control unit's I/O stall protocol. An IN or OUT
//   instruction raises enterFlag; the stall is released for one cycle
//   after a debounced press-and-release of the Enter key.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     cu_inSignal     current instruction is IN
//     cu_showDisplay  current instruction is OUT
//     out_value       register operand for OUT
//     enter_n         raw Enter key, active-low
//     switches        raw switch bank
//     enterFlag       stall request to control unit
//     in_data         value written back by IN
//     in_valid        one-cycle IN write-back strobe
//     disp_data       value driven to the 7-segment driver
//     busy            FSM not in IDLE
//   Build option: define IO_SIGN_EXT_EN to sign-extend the switch value
//   into in_data (zero-extended otherwise).
module io_handshake
  import io_handshake_pkg::*;
#(
  parameter int unsigned DATA_W          = IO_DATA_W,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cu_inSignal,
  input  logic              cu_showDisplay,
  input  logic [DATA_W-1:0] out_value,
  input  logic              enter_n,
  input  logic [SW_W-1:0]   switches,
  output logic              enterFlag,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy
);

  io_state_e         r_state;
  io_state_e         w_state_nxt;
  logic              w_key_db;
  logic              r_key_db_q;
  logic              w_io_req;
  logic              w_key_rise;
  logic              w_key_fall;
  logic [SW_W-1:0]   r_in_latch;
  logic [DATA_W-1:0] r_disp;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .raw_n(enter_n),
    .db   (w_key_db)
  );

  assign w_io_req   = cu_inSignal | cu_showDisplay;
  // edges only: a key already held when the request arrives never advances
  assign w_key_rise =  w_key_db & ~r_key_db_q;
  assign w_key_fall = ~w_key_db &  r_key_db_q;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:         if (w_io_req)   w_state_nxt = WAIT_PRESS;
      WAIT_PRESS:   if (w_key_rise) w_state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: if (w_key_fall) w_state_nxt = DONE;
      DONE:                         w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_key_db_q <= 1'b0;
      r_in_latch <= '0;
      r_disp     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_db_q <= w_key_db;
      if (r_state == IDLE && cu_showDisplay)
        r_disp <= out_value;
      if (r_state == WAIT_PRESS && w_key_rise)
        r_in_latch <= switches;
    end
  end

  // stall holds through the whole wait even if the decoder drops the request
  always_comb begin
    enterFlag = 1'b0;
    unique case (r_state)
      IDLE:         enterFlag = w_io_req;
      WAIT_PRESS:   enterFlag = 1'b1;
      WAIT_RELEASE: enterFlag = 1'b1;
      DONE:         enterFlag = 1'b0;
      default:      enterFlag = 1'b0;
    endcase
  end

  // fill first, then overlay the latch so SW_W == DATA_W needs no special case
  always_comb begin
`ifdef IO_SIGN_EXT_EN
    in_data = {DATA_W{r_in_latch[SW_W-1]}};
`else
    in_data = '0;
`endif
    in_data[SW_W-1:0] = r_in_latch;
  end

  assign in_valid  = (r_state == DONE) & cu_inSignal;
  assign disp_data = r_disp;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_io_handshake.sv
module tb_io_handshake;
  import io_handshake_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cu_inSignal;
  logic        cu_showDisplay;
  logic [31:0] out_value;
  logic        enter_n;
  logic [15:0] switches;
  logic        enterFlag;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] disp_data;
  logic        busy;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  int n_rise = 0;

  always #5 clk = ~clk;

  io_handshake #(
    .DATA_W         (32),
    .SW_W           (16),
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cu_inSignal   (cu_inSignal),
    .cu_showDisplay(cu_showDisplay),
    .out_value     (out_value),
    .enter_n       (enter_n),
    .switches      (switches),
    .enterFlag     (enterFlag),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .disp_data     (disp_data),
    .busy          (busy)
  );

  always @(posedge clk) if (u_dut.r_state == DONE) n_done++;
  always @(posedge u_dut.u_deb.db) n_rise++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press_release(input int hold);
    enter_n = 1'b0;
    repeat (hold) tick();
    enter_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (u_dut.r_state == DONE) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    int r0;
    logic [31:0] exp_ext;

    rst = 1'b1; cu_inSignal = 1'b0; cu_showDisplay = 1'b0;
    out_value = '0; enter_n = 1'b1; switches = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_flag",  32'(enterFlag), 32'd0);
    chk("rst_idata", in_data,        32'd0);
    chk("rst_ivld",  32'(in_valid),  32'd0);
    chk("rst_disp",  disp_data,      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_db",    32'(u_dut.u_deb.db), 32'd0);

    // IN with a clean key
    cu_inSignal = 1'b1; switches = 16'h0025; #1;
    chk("in_flag_idle", 32'(enterFlag), 32'd1);
    tick();
    chk("in_state_wp", 32'(u_dut.r_state), 32'(WAIT_PRESS));
    chk("in_busy",     32'(busy),          32'd1);
    tick();
    enter_n = 1'b0;
    repeat (5) tick();
    chk("in_db_5", 32'(u_dut.u_deb.db), 32'd0);
    tick();
    chk("in_db_6", 32'(u_dut.u_deb.db), 32'd1);
    tick();
    chk("in_state_wr", 32'(u_dut.r_state), 32'(WAIT_RELEASE));
    chk("in_flag_wr",  32'(enterFlag),     32'd1);
    repeat (13) tick();
    enter_n = 1'b1;
    repeat (6) tick();
    chk("in_db_fall", 32'(u_dut.u_deb.db), 32'd0);
    chk("in_flag_6",  32'(enterFlag),      32'd1);
    chk("in_ivld_6",  32'(in_valid),       32'd0);
    tick();
    chk("in_state_done", 32'(u_dut.r_state), 32'(DONE));
    chk("in_ivld",       32'(in_valid),      32'd1);
    chk("in_idata",      in_data,            32'h0000_0025);
    chk("in_flag_done",  32'(enterFlag),     32'd0);
    cu_inSignal = 1'b0;
    tick();
    chk("in_busy_end", 32'(busy),     32'd0);
    chk("in_ivld_end", 32'(in_valid), 32'd0);
    chk("in_hold",     in_data,       32'h0000_0025);

    // OUT
    cu_showDisplay = 1'b1; out_value = 32'hDEAD_BEEF; #1;
    chk("out_flag", 32'(enterFlag), 32'd1);
    tick();
    chk("out_disp", disp_data, 32'hDEAD_BEEF);
    press_release(10);
    wait_done(20, cyc);
    chk("out_lat",       32'(cyc),       32'd7);
    chk("out_ivld",      32'(in_valid),  32'd0);
    chk("out_flag_done", 32'(enterFlag), 32'd0);
    cu_showDisplay = 1'b0; out_value = 32'h1234_5678;
    repeat (5) tick();
    chk("out_disp_hold", disp_data, 32'hDEAD_BEEF);

    // bouncing key
    d0 = n_done; r0 = n_rise;
    cu_inSignal = 1'b1; switches = 16'h1234;
    tick();
    for (int i = 0; i < 6; i++) begin
      enter_n = (i % 2 == 1);
      repeat (2) tick();
    end
    enter_n = 1'b0;
    repeat (5) tick();
    chk("bnc_db_5", 32'(u_dut.u_deb.db), 32'd0);
    tick();
    chk("bnc_db_6", 32'(u_dut.u_deb.db), 32'd1);
    repeat (8) tick();
    enter_n = 1'b1;
    wait_done(20, cyc);
    chk("bnc_lat",   32'(cyc),      32'd7);
    chk("bnc_idata", in_data,       32'h0000_1234);
    cu_inSignal = 1'b0;
    repeat (3) tick();
    chk("bnc_rises", 32'(n_rise - r0), 32'd1);
    chk("bnc_dones", 32'(n_done - d0), 32'd1);

    // key already held when the request arrives; also sign extension
    enter_n = 1'b0;
    repeat (10) tick();
    d0 = n_done;
    cu_inSignal = 1'b1; switches = 16'hFFFE;
    repeat (10) tick();
    chk("held_wp", 32'(u_dut.r_state), 32'(WAIT_PRESS));
    enter_n = 1'b1;
    repeat (10) tick();
    chk("held_wp_rel", 32'(u_dut.r_state), 32'(WAIT_PRESS));
    press_release(10);
    wait_done(20, cyc);
    chk("held_lat", 32'(cyc), 32'd7);
`ifdef IO_SIGN_EXT_EN
    exp_ext = 32'hFFFF_FFFE;
`else
    exp_ext = 32'h0000_FFFE;
`endif
    chk("held_idata", in_data, exp_ext);
    cu_inSignal = 1'b0;
    repeat (3) tick();
    chk("held_dones", 32'(n_done - d0), 32'd1);

    // IN and OUT together
    cu_inSignal = 1'b1; cu_showDisplay = 1'b1;
    out_value = 32'hCAFE_0001; switches = 16'h0042;
    tick();
    chk("both_disp", disp_data, 32'hCAFE_0001);
    press_release(10);
    wait_done(20, cyc);
    chk("both_ivld",  32'(in_valid), 32'd1);
    chk("both_idata", in_data,       32'h0000_0042);
    cu_inSignal = 1'b0; cu_showDisplay = 1'b0;
    tick();

    // request withdrawn mid-wait: sequence still completes
    cu_showDisplay = 1'b1; out_value = 32'h0000_0011;
    tick();
    cu_showDisplay = 1'b0; #1;
    chk("drop_flag", 32'(enterFlag), 32'd1);
    press_release(10);
    wait_done(20, cyc);
    chk("drop_lat",       32'(cyc),       32'd7);
    chk("drop_flag_done", 32'(enterFlag), 32'd0);
    chk("drop_disp",      disp_data,      32'h0000_0011);
    tick();

    // reset while in WAIT_RELEASE
    cu_inSignal = 1'b1; switches = 16'h00AA;
    tick();
    enter_n = 1'b0;
    repeat (7) tick();
    chk("rwr_state", 32'(u_dut.r_state), 32'(WAIT_RELEASE));
    rst = 1'b1; cu_inSignal = 1'b0;
    tick();
    rst = 1'b0;
    chk("rwr_idle",  32'(u_dut.r_state), 32'(IDLE));
    chk("rwr_disp",  disp_data,          32'd0);
    chk("rwr_ivld",  32'(in_valid),      32'd0);
    chk("rwr_idata", in_data,            32'd0);
    d0 = n_done;
    repeat (10) tick();
    enter_n = 1'b1;
    repeat (15) tick();
    chk("rwr_nodone", 32'(n_done - d0), 32'd0);
    chk("rwr_busy",   32'(busy),        32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
